// File: rtl/peg_scorer.sv
// Scoring datapath for a four-peg code-breaking game: holds the secret code and
// the current guess, scores one position per compare step and publishes results.
module peg_scorer #(
  parameter int COLOR_W   = 3,
  parameter int MAX_TURNS = 10,
  parameter int TURN_W    = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [COLOR_W-1:0] data_in,
  input  logic               load_code_1,
  input  logic               load_code_2,
  input  logic               load_code_3,
  input  logic               load_code_4,
  input  logic               load_guess_1,
  input  logic               load_guess_2,
  input  logic               load_guess_3,
  input  logic               load_guess_4,
  input  logic               compare,
  input  logic [1:0]         compare_i,
  input  logic               reach_result_4,
  output logic [2:0]         black,
  output logic [2:0]         white,
  output logic               result_valid,
  output logic               win,
  output logic               game_over,
  output logic [TURN_W-1:0]  turn_count
);

  localparam logic [TURN_W-1:0] MaxTurns = TURN_W'(MAX_TURNS);

  logic [COLOR_W-1:0] code_q  [4];
  logic [COLOR_W-1:0] code_d  [4];
  logic [COLOR_W-1:0] guess_q [4];
  logic [COLOR_W-1:0] guess_d [4];

  logic [2:0]        accBlack_q, accBlack_d;
  logic [2:0]        accWhite_q, accWhite_d;
  logic [3:0]        used_q, used_d;
  logic [2:0]        black_q, black_d;
  logic [2:0]        white_q, white_d;
  logic              win_q, win_d;
  logic              gameOver_q, gameOver_d;
  logic              resultValid_q, resultValid_d;
  logic [TURN_W-1:0] turnCount_q, turnCount_d;

  logic [3:0]         loadCode;
  logic [3:0]         loadGuess;
  logic [3:0]         exact;
  logic [2:0]         baseBlack;
  logic [2:0]         baseWhite;
  logic [3:0]         baseUsed;
  logic [COLOR_W-1:0] pegGuess;
  logic               found;
  logic [1:0]         matchIdx;
  logic               doCompare;
  logic [TURN_W:0]    turnInc;

  assign loadCode  = {load_code_4, load_code_3, load_code_2, load_code_1};
  assign loadGuess = {load_guess_4, load_guess_3, load_guess_2, load_guess_1};

  always_comb begin
    exact = '0;
    for (int k = 0; k < 4; k++) begin
      exact[k] = (code_q[k] == guess_q[k]);
    end
  end

  // Step 0 starts a fresh evaluation, so the accumulators are scored from zero.
  always_comb begin
    baseBlack = (compare_i == 2'd0) ? 3'd0 : accBlack_q;
    baseWhite = (compare_i == 2'd0) ? 3'd0 : accWhite_q;
    baseUsed  = (compare_i == 2'd0) ? 4'd0 : used_q;
    pegGuess  = guess_q[compare_i];
    found     = 1'b0;
    matchIdx  = 2'd0;
    // Searching downward lets the lowest eligible code peg win.
    for (int j = 3; j >= 0; j--) begin
      if (!exact[j] && !baseUsed[j] && (code_q[j] == pegGuess)) begin
        found    = 1'b1;
        matchIdx = 2'(j);
      end
    end
  end

  assign doCompare = compare && !reach_result_4;
  assign turnInc   = {1'b0, turnCount_q} + {{TURN_W{1'b0}}, 1'b1};

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      code_d[k]  = code_q[k];
      guess_d[k] = guess_q[k];
    end
    accBlack_d    = accBlack_q;
    accWhite_d    = accWhite_q;
    used_d        = used_q;
    black_d       = black_q;
    white_d       = white_q;
    win_d         = win_q;
    gameOver_d    = gameOver_q;
    resultValid_d = 1'b0;
    turnCount_d   = turnCount_q;

    for (int k = 0; k < 4; k++) begin
      if (loadCode[k]) begin
        code_d[k] = data_in;
      end
      if (loadGuess[k] && !gameOver_q) begin
        guess_d[k] = data_in;
      end
    end

    if (doCompare) begin
      accBlack_d = baseBlack;
      accWhite_d = baseWhite;
      used_d     = baseUsed;
      if (exact[compare_i]) begin
        accBlack_d = baseBlack + 3'd1;
      end else if (found) begin
        used_d[matchIdx] = 1'b1;
        accWhite_d       = baseWhite + 3'd1;
      end
    end

    if (reach_result_4) begin
      black_d       = accBlack_q;
      white_d       = accWhite_q;
      win_d         = (accBlack_q == 3'd4);
      resultValid_d = 1'b1;
      if (!gameOver_q) begin
        if (turnCount_q < MaxTurns) begin
          turnCount_d = turnInc[TURN_W-1:0];
        end
        gameOver_d = (accBlack_q == 3'd4) || (turnInc >= {1'b0, MaxTurns});
      end
    end

    // Loading the first code peg marks a new game and overrides any publish.
    if (load_code_1) begin
      turnCount_d = '0;
      win_d       = 1'b0;
      gameOver_d  = 1'b0;
      black_d     = 3'd0;
      white_d     = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 4; k++) begin
        code_q[k]  <= '0;
        guess_q[k] <= '0;
      end
      accBlack_q    <= 3'd0;
      accWhite_q    <= 3'd0;
      used_q        <= 4'd0;
      black_q       <= 3'd0;
      white_q       <= 3'd0;
      win_q         <= 1'b0;
      gameOver_q    <= 1'b0;
      resultValid_q <= 1'b0;
      turnCount_q   <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        code_q[k]  <= code_d[k];
        guess_q[k] <= guess_d[k];
      end
      accBlack_q    <= accBlack_d;
      accWhite_q    <= accWhite_d;
      used_q        <= used_d;
      black_q       <= black_d;
      white_q       <= white_d;
      win_q         <= win_d;
      gameOver_q    <= gameOver_d;
      resultValid_q <= resultValid_d;
      turnCount_q   <= turnCount_d;
    end
  end

  assign black        = black_q;
  assign white        = white_q;
  assign win          = win_q;
  assign game_over    = gameOver_q;
  assign result_valid = resultValid_q;
  assign turn_count   = turnCount_q;

endmodule

// File: tb/tb_peg_scorer.sv
// Self-checking bench for peg_scorer: a reference scorer predicts each published
// result into a queue, which is popped when result_valid appears.
module tb_peg_scorer;

  typedef struct packed {
    logic [2:0] b;
    logic [2:0] w;
    logic       win;
    logic [3:0] turns;
    logic       over;
  } exp_t;

  logic       clk;
  logic       resetn;
  logic [2:0] data_in;
  logic       load_code_1, load_code_2, load_code_3, load_code_4;
  logic       load_guess_1, load_guess_2, load_guess_3, load_guess_4;
  logic       compare;
  logic [1:0] compare_i;
  logic       reach_result_4;
  logic [2:0] black, white;
  logic       result_valid, win, game_over;
  logic [3:0] turn_count;

  exp_t  sbQ[$];
  int    vectors;
  int    miscompares;
  int    mTurns;
  bit    mOver;
  logic [11:0] mCode;
  logic [11:0] mGuess;

  peg_scorer #(.COLOR_W(3), .MAX_TURNS(10), .TURN_W(4)) dut (
    .clk(clk), .resetn(resetn), .data_in(data_in),
    .load_code_1(load_code_1), .load_code_2(load_code_2),
    .load_code_3(load_code_3), .load_code_4(load_code_4),
    .load_guess_1(load_guess_1), .load_guess_2(load_guess_2),
    .load_guess_3(load_guess_3), .load_guess_4(load_guess_4),
    .compare(compare), .compare_i(compare_i), .reach_result_4(reach_result_4),
    .black(black), .white(white), .result_valid(result_valid), .win(win),
    .game_over(game_over), .turn_count(turn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t sampleOuts();
    exp_t o;
    o.b = black; o.w = white; o.win = win; o.turns = turn_count; o.over = game_over;
    return o;
  endfunction

  // Colour-count scorer: exact hits, then per-colour minimum over the rest.
  task automatic refScore(input logic [11:0] c, input logic [11:0] g,
                          output logic [2:0] b, output logic [2:0] w);
    int cc[8];
    int gc[8];
    int nb, nw;
    nb = 0; nw = 0;
    for (int k = 0; k < 8; k++) begin cc[k] = 0; gc[k] = 0; end
    for (int k = 0; k < 4; k++) begin
      if (c[k*3 +: 3] == g[k*3 +: 3]) nb++;
      else begin cc[c[k*3 +: 3]]++; gc[g[k*3 +: 3]]++; end
    end
    for (int k = 0; k < 8; k++) nw += (cc[k] < gc[k]) ? cc[k] : gc[k];
    b = 3'(nb);
    w = 3'(nw);
  endtask

  task automatic clearIns();
    load_code_1 = 0; load_code_2 = 0; load_code_3 = 0; load_code_4 = 0;
    load_guess_1 = 0; load_guess_2 = 0; load_guess_3 = 0; load_guess_4 = 0;
    compare = 0; reach_result_4 = 0;
  endtask

  task automatic loadCodeAll(input logic [11:0] c);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      clearIns();
      data_in = c[k*3 +: 3];
      case (k)
        0: load_code_1 = 1;
        1: load_code_2 = 1;
        2: load_code_3 = 1;
        default: load_code_4 = 1;
      endcase
    end
    @(negedge clk);
    clearIns();
    mCode = c; mTurns = 0; mOver = 0;
  endtask

  task automatic loadGuessAll(input logic [11:0] g);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      clearIns();
      data_in = g[k*3 +: 3];
      case (k)
        0: load_guess_1 = 1;
        1: load_guess_2 = 1;
        2: load_guess_3 = 1;
        default: load_guess_4 = 1;
      endcase
    end
    @(negedge clk);
    clearIns();
    if (!mOver) mGuess = g;
  endtask

  task automatic pushExpect();
    exp_t e;
    logic [2:0] b, w;
    refScore(mCode, mGuess, b, w);
    if (!mOver) begin
      if (mTurns < 10) mTurns++;
      mOver = (b == 3'd4) || (mTurns >= 10);
    end
    e.b = b; e.w = w; e.win = (b == 3'd4); e.turns = 4'(mTurns); e.over = mOver;
    sbQ.push_back(e);
  endtask

  task automatic scoreGuess(output exp_t obs, output bit timedOut, output bit pulseOff);
    int n;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clearIns();
      compare = 1; compare_i = 2'(i);
    end
    @(negedge clk);
    clearIns();
    reach_result_4 = 1;
    pushExpect();
    @(posedge clk); #1;
    clearIns();
    n = 0;
    while (result_valid !== 1'b1 && n < 5) begin
      @(posedge clk); #1;
      n++;
    end
    timedOut = (result_valid !== 1'b1);
    obs = sampleOuts();
    @(posedge clk); #1;
    pulseOff = (result_valid === 1'b0);
  endtask

  task automatic test_reset();
    exp_t obs;
    resetn = 0;
    clearIns(); data_in = 0; compare_i = 0;
    mTurns = 0; mOver = 0; mCode = 0; mGuess = 0;
    #12;
    obs = sampleOuts();
    vectors++;
    if (obs !== '0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset: got %h rv=%b, want 0 rv=0", obs, result_valid);
    end
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_exact_win();
    exp_t obs, e; bit to, off;
    loadCodeAll(12'o4321);
    loadGuessAll(12'o4321);
    scoreGuess(obs, to, off);
    e = sbQ.pop_front();
    vectors++;
    if (to || obs !== e) begin
      miscompares++;
      $display("[TB] FAIL exact_win: got b=%0d w=%0d win=%0d t=%0d go=%0d to=%0b, want b=%0d w=%0d win=%0d t=%0d go=%0d",
               obs.b, obs.w, obs.win, obs.turns, obs.over, to, e.b, e.w, e.win, e.turns, e.over);
    end
    vectors++;
    if (!off) begin
      miscompares++;
      $display("[TB] FAIL exact_win_pulse: result_valid=%b after one cycle, want 0", result_valid);
    end
  endtask

  task automatic test_all_white();
    exp_t obs, e; bit to, off;
    loadCodeAll(12'o4321);
    loadGuessAll(12'o1234);
    scoreGuess(obs, to, off);
    e = sbQ.pop_front();
    vectors++;
    if (to || obs !== e) begin
      miscompares++;
      $display("[TB] FAIL all_white: got b=%0d w=%0d win=%0d t=%0d go=%0d to=%0b, want b=%0d w=%0d win=%0d t=%0d go=%0d",
               obs.b, obs.w, obs.win, obs.turns, obs.over, to, e.b, e.w, e.win, e.turns, e.over);
    end
  endtask

  task automatic test_duplicates();
    exp_t obs, e; bit to, off;
    loadCodeAll(12'o2211);
    loadGuessAll(12'o1121);
    scoreGuess(obs, to, off);
    e = sbQ.pop_front();
    vectors++;
    if (to || obs !== e || obs.b !== 3'd1 || obs.w !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL duplicates: got b=%0d w=%0d t=%0d to=%0b, want b=1 w=2 t=%0d",
               obs.b, obs.w, obs.turns, to, e.turns);
    end
  endtask

  task automatic test_back_to_back();
    exp_t obs, e; bit to, off;
    logic [11:0] c, g;
    for (int r = 0; r < 6; r++) begin
      c = 0; g = 0;
      for (int k = 0; k < 4; k++) begin
        c[k*3 +: 3] = 3'($urandom_range(0, 3));
        g[k*3 +: 3] = 3'($urandom_range(0, 3));
      end
      loadCodeAll(c);
      loadGuessAll(g);
      scoreGuess(obs, to, off);
      e = sbQ.pop_front();
      vectors++;
      if (to || obs !== e || !off) begin
        miscompares++;
        $display("[TB] FAIL back_to_back[%0d] code=%o guess=%o: got b=%0d w=%0d win=%0d t=%0d to=%0b off=%0b, want b=%0d w=%0d win=%0d t=%0d",
                 r, c, g, obs.b, obs.w, obs.win, obs.turns, to, off, e.b, e.w, e.win, e.turns);
      end
    end
  endtask

  task automatic test_turn_limit();
    exp_t obs, e; bit to, off;
    loadCodeAll(12'o5555);
    for (int t = 1; t <= 11; t++) begin
      loadGuessAll(12'o3210);
      scoreGuess(obs, to, off);
      e = sbQ.pop_front();
      vectors++;
      if (to || obs !== e || !off) begin
        miscompares++;
        $display("[TB] FAIL turn_limit[%0d]: got b=%0d w=%0d t=%0d go=%0d to=%0b off=%0b, want b=%0d w=%0d t=%0d go=%0d",
                 t, obs.b, obs.w, obs.turns, obs.over, to, off, e.b, e.w, e.turns, e.over);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t obs, e; bit to, off;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clearIns();
      compare = 1; compare_i = 2'(i);
    end
    @(posedge clk); #1;
    clearIns();
    #2 resetn = 0;
    #1;
    obs = sampleOuts();
    vectors++;
    if (obs !== '0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got %h rv=%b, want 0 rv=0", obs, result_valid);
    end
    mTurns = 0; mOver = 0; mCode = 0; mGuess = 0;
    @(negedge clk);
    resetn = 1;
    loadCodeAll(12'o4321);
    loadGuessAll(12'o4321);
    scoreGuess(obs, to, off);
    e = sbQ.pop_front();
    vectors++;
    if (to || obs !== e) begin
      miscompares++;
      $display("[TB] FAIL rescore: got b=%0d w=%0d win=%0d t=%0d go=%0d to=%0b, want b=%0d w=%0d win=%0d t=%0d go=%0d",
               obs.b, obs.w, obs.win, obs.turns, obs.over, to, e.b, e.w, e.win, e.turns, e.over);
    end
  endtask

  task automatic test_new_game();
    exp_t obs;
    @(negedge clk);
    clearIns();
    data_in = 3'd6;
    load_code_1 = 1;
    @(posedge clk); #1;
    clearIns();
    mTurns = 0; mOver = 0; mCode[2:0] = 3'd6;
    obs = sampleOuts();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("[TB] FAIL new_game: got b=%0d w=%0d win=%0d t=%0d go=%0d, want all 0",
               obs.b, obs.w, obs.win, obs.turns, obs.over);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_exact_win();
    test_all_white();
    test_duplicates();
    test_back_to_back();
    test_turn_limit();
    test_reset_mid();
    test_new_game();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
